// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared types for the line refill controller: FSM state encoding and access sizing.
package cache_line_fill_ctrl_pkg;

    localparam int WORD_BYTES_LOG2 = 2;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL_ISSUE,
        FILL_WAIT,
        DONE
    } fill_state_e;

    // A direct-mapped cache still carries a one-bit way index.
    function automatic int way_width(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/cache_line_fill_ctrl_if.sv
// Miss request, single-word memory port and data-array write port of the refill controller.
interface cache_line_fill_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int SET_SIZE = 2,
    parameter int WAYW     = 1,
    parameter int WLW      = 3
);
    import cache_line_fill_ctrl_pkg::*;

    logic                   miss_valid;
    logic                   miss_ready;
    logic [SET_SIZE-1:0]    miss_set;
    logic [WAYW-1:0]        miss_way;
    logic                   miss_dirty;
    logic [XLEN-1:0]        miss_wb_addr;
    logic [XLEN-1:0]        miss_fill_addr;
    logic                   fill_done;

    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_we;
    logic [XLEN-1:0]        mem_req_addr;
    logic [XLEN-1:0]        mem_req_wdata;
    logic                   mem_rsp_valid;
    logic [XLEN-1:0]        mem_rsp_rdata;

    logic                   dl_perform_write;
    logic [SET_SIZE-1:0]    dl_set;
    logic [WAYW-1:0]        dl_selected_way;
    logic [WLW-1:0]         dl_word_select;
    logic [1:0]             dl_byte_select;
    memory_operation_size_e dl_op_size;
    logic [XLEN-1:0]        dl_word_to_store;
    logic [XLEN-1:0]        dl_fetched_word;

    modport master (
        input  miss_valid, miss_set, miss_way, miss_dirty, miss_wb_addr, miss_fill_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, dl_fetched_word,
        output miss_ready, fill_done,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output dl_perform_write, dl_set, dl_selected_way, dl_word_select,
        output dl_byte_select, dl_op_size, dl_word_to_store
    );

    modport slave (
        output miss_valid, miss_set, miss_way, miss_dirty, miss_wb_addr, miss_fill_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, dl_fetched_word,
        input  miss_ready, fill_done,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  dl_perform_write, dl_set, dl_selected_way, dl_word_select,
        input  dl_byte_select, dl_op_size, dl_word_to_store
    );

endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Refills one cache line on a miss, writing back a dirty victim word by word first.
// Latency: clean miss with 0-wait memory and 1-cycle response = 2 cycles/word + 1 DONE cycle.
// Backpressure: request held stable while mem_req_ready=0; one read outstanding; miss held by requester.
module cache_line_fill_ctrl
    import cache_line_fill_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_SETS       = 4,
    parameter int SET_SIZE       = 2,
    parameter int WORDS_PER_LINE = 8,
    parameter int ASSOC          = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    cache_line_fill_ctrl_if.master bus
);

    localparam int WAYW = way_width(ASSOC);
    localparam int WLW  = $clog2(WORDS_PER_LINE);
    localparam logic [WLW-1:0]  LAST_WORD = WLW'(WORDS_PER_LINE - 1);
    localparam logic [XLEN-1:0] LINE_MASK =
        ~((XLEN'(1) << (WLW + WORD_BYTES_LOG2)) - XLEN'(1));

    fill_state_e         state;
    logic [WLW-1:0]      cnt;
    logic [SET_SIZE-1:0] set_q;
    logic [WAYW-1:0]     way_q;
    logic [XLEN-1:0]     wb_base;
    logic [XLEN-1:0]     fill_base;
    logic                miss_ready_q;
    logic                req_vld_q;
    logic                req_we_q;
    logic                done_q;

    logic req_hs;
    logic rsp_hs;

    assign req_hs = req_vld_q & bus.mem_req_ready;
    assign rsp_hs = (state == FILL_WAIT) & bus.mem_rsp_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            set_q        <= '0;
            way_q        <= '0;
            wb_base      <= '0;
            fill_base    <= '0;
            miss_ready_q <= 1'b0;
            req_vld_q    <= 1'b0;
            req_we_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.miss_valid && miss_ready_q) begin
                        set_q        <= bus.miss_set;
                        way_q        <= bus.miss_way;
                        wb_base      <= bus.miss_wb_addr & LINE_MASK;
                        fill_base    <= bus.miss_fill_addr & LINE_MASK;
                        cnt          <= '0;
                        miss_ready_q <= 1'b0;
                        req_vld_q    <= 1'b1;
                        req_we_q     <= bus.miss_dirty;
                        state        <= bus.miss_dirty ? WRITEBACK : FILL_ISSUE;
                    end else begin
                        miss_ready_q <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    // Valid stays high across the switch to the first fill read.
                    if (req_hs) begin
                        if (cnt == LAST_WORD) begin
                            cnt      <= '0;
                            req_we_q <= 1'b0;
                            state    <= FILL_ISSUE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FILL_ISSUE: begin
                    if (req_hs) begin
                        req_vld_q <= 1'b0;
                        state     <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            req_vld_q <= 1'b1;
                            state     <= FILL_ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_q       <= 1'b0;
                    miss_ready_q <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.miss_ready       = miss_ready_q;
    assign bus.fill_done        = done_q;
    assign bus.mem_req_valid    = req_vld_q;
    assign bus.mem_req_we       = req_we_q;
    assign bus.mem_req_addr     = ((state == WRITEBACK) ? wb_base : fill_base)
                                | (XLEN'(cnt) << WORD_BYTES_LOG2);
    assign bus.mem_req_wdata    = bus.dl_fetched_word;
    assign bus.dl_perform_write = rsp_hs;
    assign bus.dl_set           = set_q;
    assign bus.dl_selected_way  = way_q;
    assign bus.dl_word_select   = cnt;
    assign bus.dl_byte_select   = 2'd0;
    assign bus.dl_op_size       = MEM_WORD;
    assign bus.dl_word_to_store = bus.mem_rsp_rdata;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && bus.mem_rsp_valid && state != FILL_WAIT)
            assert (1'b0) else $warning("mem_rsp_valid with no read outstanding, ignored");
        if (reset_n && bus.miss_valid && miss_ready_q)
            assert (32'(bus.miss_set) < NUM_SETS) else $error("miss_set out of range");
    end
`endif

endmodule
